// File: rtl/rf_scoreboard.sv
// Parametrised multi-port register file with two writeback ports, same-cycle
// write forwarding and a per-register pending-write (busy) scoreboard.
module rf_scoreboard #(
    parameter  int DW       = 8,
    parameter  int NREGS    = 8,
    parameter  int NRD      = 2,
    parameter  int ZERO_REG = 1,
    localparam int AW       = $clog2(NREGS)
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic [NRD*AW-1:0] rdAddr,
    output logic [NRD*DW-1:0] rdVal,
    output logic [NRD-1:0]    rdBusy,
    input  logic              wrEnA,
    input  logic [AW-1:0]     wrAddrA,
    input  logic [DW-1:0]     wrValA,
    input  logic              wrEnB,
    input  logic [AW-1:0]     wrAddrB,
    input  logic [DW-1:0]     wrValB,
    input  logic              issueEn,
    input  logic [AW-1:0]     issueAddr,
    output logic              anyBusy,
    output logic              wrCollide
);

    logic [DW-1:0]    regs [NREGS];
    logic [NREGS-1:0] busy;
    logic             collide_q;

    function automatic logic is_zero(input logic [AW-1:0] addr);
        return (ZERO_REG != 0) && (addr == '0);
    endfunction

    function automatic logic hit_a(input logic [AW-1:0] addr);
        return wrEnA && (wrAddrA == addr);
    endfunction

    function automatic logic hit_b(input logic [AW-1:0] addr);
        return wrEnB && (wrAddrB == addr);
    endfunction

    // NOTE: the array is reset along with the busy bits because a cleared
    // register file is part of the architectural reset state, not just control.
    always_ff @(posedge CLK) begin
        if (reset) begin
            for (int r = 0; r < NREGS; r++) regs[r] <= '0;
            busy      <= '0;
            collide_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register update in this
            // block based on pre-edge values, regardless of statement order.
            for (int r = 0; r < NREGS; r++) begin
                if (!is_zero(AW'(r))) begin
                    if (hit_b(AW'(r)))      regs[r] <= wrValB;
                    else if (hit_a(AW'(r))) regs[r] <= wrValA;

                    // A same-cycle issue belongs to a younger producer, so it wins.
                    if (issueEn && issueAddr == AW'(r))         busy[r] <= 1'b1;
                    else if (hit_a(AW'(r)) || hit_b(AW'(r)))    busy[r] <= 1'b0;
                end
            end
            collide_q <= wrEnA && wrEnB && (wrAddrA == wrAddrB) && !is_zero(wrAddrA);
        end
    end

    function automatic logic [DW-1:0] read_val(input logic [AW-1:0] addr);
        if (is_zero(addr)) return '0;
        if (hit_b(addr))   return wrValB;
        if (hit_a(addr))   return wrValA;
        return regs[addr];
    endfunction

    function automatic logic read_busy(input logic [AW-1:0] addr);
        return busy[addr] && !hit_a(addr) && !hit_b(addr);
    endfunction

    // NOTE: outputs get a default before the loop so no path can infer a latch.
    always_comb begin
        rdVal  = '0;
        rdBusy = '0;
        for (int k = 0; k < NRD; k++) begin
            rdVal[k*DW +: DW] = read_val(rdAddr[k*AW +: AW]);
            rdBusy[k]         = read_busy(rdAddr[k*AW +: AW]);
        end
    end

    assign anyBusy   = |busy;
    assign wrCollide = collide_q;

endmodule

// File: tb/tb_rf_scoreboard.sv
// Self-checking bench for rf_scoreboard: directed scenarios plus randomized
// traffic on the default configuration, and a directed sweep of a wide config.
module tb_rf_scoreboard;

    logic CLK = 1'b0;
    logic reset;
    initial forever #5 CLK = ~CLK;

    // Default configuration: DW=8, NREGS=8, NRD=2, ZERO_REG=1
    logic [5:0]  rd_addr8;
    logic [15:0] rd_val8;
    logic [1:0]  rd_busy8;
    logic        wr_en_a8, wr_en_b8, issue_en8;
    logic [2:0]  wr_addr_a8, wr_addr_b8, issue_addr8;
    logic [7:0]  wr_val_a8, wr_val_b8;
    logic        any_busy8, wr_collide8;

    // Sweep configuration: DW=16, NREGS=16, NRD=3, ZERO_REG=0
    logic [11:0] rd_addr16;
    logic [47:0] rd_val16;
    logic [2:0]  rd_busy16;
    logic        wr_en_a16, wr_en_b16, issue_en16;
    logic [3:0]  wr_addr_a16, wr_addr_b16, issue_addr16;
    logic [15:0] wr_val_a16, wr_val_b16;
    logic        any_busy16, wr_collide16;

    rf_scoreboard u_dut8 (
        .CLK(CLK), .reset(reset),
        .rdAddr(rd_addr8), .rdVal(rd_val8), .rdBusy(rd_busy8),
        .wrEnA(wr_en_a8), .wrAddrA(wr_addr_a8), .wrValA(wr_val_a8),
        .wrEnB(wr_en_b8), .wrAddrB(wr_addr_b8), .wrValB(wr_val_b8),
        .issueEn(issue_en8), .issueAddr(issue_addr8),
        .anyBusy(any_busy8), .wrCollide(wr_collide8)
    );

    rf_scoreboard #(.DW(16), .NREGS(16), .NRD(3), .ZERO_REG(0)) u_dut16 (
        .CLK(CLK), .reset(reset),
        .rdAddr(rd_addr16), .rdVal(rd_val16), .rdBusy(rd_busy16),
        .wrEnA(wr_en_a16), .wrAddrA(wr_addr_a16), .wrValA(wr_val_a16),
        .wrEnB(wr_en_b16), .wrAddrB(wr_addr_b16), .wrValB(wr_val_b16),
        .issueEn(issue_en16), .issueAddr(issue_addr16),
        .anyBusy(any_busy16), .wrCollide(wr_collide16)
    );

    int n_vec = 0;
    int n_mis = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model of the default configuration, written as sequential rules.
    logic [7:0] m_regs [8];
    bit         m_busy [8];
    bit         m_col;

    function automatic logic [7:0] m_read(input int a);
        if (a == 0) return 8'h00;
        if (wr_en_b8 && wr_addr_b8 == a) return wr_val_b8;
        if (wr_en_a8 && wr_addr_a8 == a) return wr_val_a8;
        return m_regs[a];
    endfunction

    function automatic bit m_rdbusy(input int a);
        if (wr_en_a8 && wr_addr_a8 == a) return 1'b0;
        if (wr_en_b8 && wr_addr_b8 == a) return 1'b0;
        return m_busy[a];
    endfunction

    task automatic m_update();
        if (reset) begin
            for (int r = 0; r < 8; r++) begin m_regs[r] = 8'h00; m_busy[r] = 1'b0; end
            m_col = 1'b0;
        end else begin
            m_col = wr_en_a8 && wr_en_b8 && wr_addr_a8 == wr_addr_b8 && wr_addr_a8 != 0;
            if (wr_en_a8 && wr_addr_a8 != 0) begin m_regs[wr_addr_a8] = wr_val_a8; m_busy[wr_addr_a8] = 1'b0; end
            if (wr_en_b8 && wr_addr_b8 != 0) begin m_regs[wr_addr_b8] = wr_val_b8; m_busy[wr_addr_b8] = 1'b0; end
            if (issue_en8 && issue_addr8 != 0) m_busy[issue_addr8] = 1'b1;
        end
    endtask

    task automatic drive8(input bit ea, input int aa, input int va,
                          input bit eb, input int ab, input int vb,
                          input bit ie, input int ia, input int r0, input int r1);
        wr_en_a8 = ea; wr_addr_a8 = 3'(aa); wr_val_a8 = 8'(va);
        wr_en_b8 = eb; wr_addr_b8 = 3'(ab); wr_val_b8 = 8'(vb);
        issue_en8 = ie; issue_addr8 = 3'(ia);
        rd_addr8 = {3'(r1), 3'(r0)};
    endtask

    task automatic idle16();
        wr_en_a16 = 1'b0; wr_addr_a16 = '0; wr_val_a16 = '0;
        wr_en_b16 = 1'b0; wr_addr_b16 = '0; wr_val_b16 = '0;
        issue_en16 = 1'b0; issue_addr16 = '0;
    endtask

    // Settle combinational paths, then compare both read ports with the model.
    task automatic comb8();
        #1;
        for (int k = 0; k < 2; k++) begin
            check("rdVal", 64'(rd_val8[k*8 +: 8]), 64'(m_read(int'(rd_addr8[k*3 +: 3]))));
            check("rdBusy", 64'(rd_busy8[k]), 64'(m_rdbusy(int'(rd_addr8[k*3 +: 3]))));
        end
    endtask

    // Clock edge, model update, then compare registered outputs.
    task automatic tick();
        bit any;
        @(posedge CLK);
        m_update();
        #1;
        any = 1'b0;
        for (int r = 0; r < 8; r++) any |= m_busy[r];
        check("anyBusy", 64'(any_busy8), 64'(any));
        check("wrCollide", 64'(wr_collide8), 64'(m_col));
    endtask

    initial begin
        reset = 1'b1;
        drive8(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle16();
        rd_addr16 = '0;
        tick();
        reset = 1'b0;

        // Reset state: all reads zero, not busy
        drive8(0, 0, 0, 0, 0, 0, 0, 0, 5, 7);
        comb8();
        check("reset_rd5", 64'(rd_val8[7:0]), 64'h00);
        check("reset_busy", 64'(rd_busy8), 64'h0);

        // Wide configuration: r0 writable, three independent ports
        wr_en_a16 = 1'b1; wr_addr_a16 = 4'd0;  wr_val_a16 = 16'hBEEF;
        wr_en_b16 = 1'b1; wr_addr_b16 = 4'd15; wr_val_b16 = 16'h1234;
        tick();
        idle16();
        wr_en_a16 = 1'b1; wr_addr_a16 = 4'd9; wr_val_a16 = 16'h5555;
        rd_addr16 = {4'd15, 4'd9, 4'd0};
        #1;
        check("w16_p0_r0", 64'(rd_val16[15:0]), 64'hBEEF);
        check("w16_p1_fwd", 64'(rd_val16[31:16]), 64'h5555);
        check("w16_p2_r15", 64'(rd_val16[47:32]), 64'h1234);
        tick();
        idle16();
        issue_en16 = 1'b1; issue_addr16 = 4'd0;
        tick();
        idle16();
        #1;
        check("w16_p1_r9", 64'(rd_val16[31:16]), 64'h5555);
        check("w16_r0_busy", 64'(rd_busy16), 64'b001);
        check("w16_anybusy", 64'(any_busy16), 64'h1);

        // Reset clear: reset overrides a same-cycle write, forwarding still visible
        drive8(1, 3, 'hA5, 0, 0, 0, 0, 0, 3, 0);
        comb8(); tick();
        reset = 1'b1;
        drive8(1, 3, 'h11, 0, 0, 0, 0, 0, 3, 0);
        comb8(); tick();
        reset = 1'b0;
        drive8(0, 0, 0, 0, 0, 0, 0, 0, 3, 0);
        comb8();
        check("rst_clear_r3", 64'(rd_val8[7:0]), 64'h00);
        check("rst_anybusy", 64'(any_busy8), 64'h0);

        // Forwarding
        drive8(1, 5, 'h3C, 0, 0, 0, 0, 0, 5, 5);
        comb8();
        check("fwd_r5", 64'(rd_val8[7:0]), 64'h3C);
        tick();
        drive8(0, 0, 0, 0, 0, 0, 0, 0, 5, 0);
        comb8();
        check("stored_r5", 64'(rd_val8[7:0]), 64'h3C);
        tick();

        // Dual-write collision: B wins, one-cycle wrCollide pulse
        drive8(1, 2, 'h01, 1, 2, 'h02, 0, 0, 2, 0);
        comb8();
        check("coll_fwd", 64'(rd_val8[7:0]), 64'h02);
        tick();
        check("coll_pulse", 64'(wr_collide8), 64'h1);
        drive8(0, 0, 0, 0, 0, 0, 0, 0, 2, 0);
        comb8();
        check("coll_stored", 64'(rd_val8[7:0]), 64'h02);
        tick();
        check("coll_end", 64'(wr_collide8), 64'h0);
        drive8(1, 0, 'h01, 1, 0, 'h02, 0, 0, 0, 0);
        comb8();
        check("coll_r0", 64'(rd_val8[7:0]), 64'h00);
        tick();
        check("coll_r0_flag", 64'(wr_collide8), 64'h0);

        // Scoreboard: issue, then satisfy with port B
        drive8(0, 0, 0, 0, 0, 0, 1, 4, 4, 0);
        comb8(); tick();
        drive8(0, 0, 0, 0, 0, 0, 0, 0, 4, 0);
        comb8();
        check("sb_busy", 64'(rd_busy8[0]), 64'h1);
        check("sb_anybusy", 64'(any_busy8), 64'h1);
        drive8(0, 0, 0, 1, 4, 'h77, 0, 0, 4, 0);
        comb8();
        check("sb_satisfied", 64'(rd_busy8[0]), 64'h0);
        check("sb_fwd", 64'(rd_val8[7:0]), 64'h77);
        tick();
        check("sb_cleared", 64'(any_busy8), 64'h0);

        // Issue wins over a same-cycle write to an already busy register
        drive8(0, 0, 0, 0, 0, 0, 1, 6, 6, 0);
        comb8(); tick();
        drive8(1, 6, 'h5A, 0, 0, 0, 1, 6, 6, 0);
        comb8(); tick();
        drive8(0, 0, 0, 0, 0, 0, 0, 0, 6, 6);
        comb8();
        check("iw_busy", 64'(rd_busy8[0]), 64'h1);
        check("iw_data", 64'(rd_val8[7:0]), 64'h5A);
        tick();

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 39) == 0);
            drive8($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 255),
                   $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 255),
                   ($urandom_range(0, 2) == 0), $urandom_range(0, 7),
                   $urandom_range(0, 7), $urandom_range(0, 7));
            comb8();
            tick();
        end
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/rf_scoreboard.md
# rf_scoreboard

Parametrised multi-port register file with write-through forwarding and a per-register pending-write scoreboard. It is the next-generation replacement for the core's 8x8 register file. It adds configurable width, depth and read-port count, and a second writeback port so ALU and load results can retire in the same cycle. Busy bits on each register let issue logic detect RAW hazards without a separate hazard unit.

## Interface
- `DW`, 8, data width in bits.
- `NREGS`, 8, number of registers; must be a power of 2, minimum 2. `AW = $clog2(NREGS)`.
- `NRD`, 2, number of read ports, range 1..4.
- `ZERO_REG`, 1, when 1 register 0 is hardwired to zero and never busy.

- `CLK`  in  1  clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `rdAddr`  in  NRD*AW  packed read addresses; port k is bits [k*AW +: AW].
- `rdVal`  out  NRD*DW  packed read data, combinational.
- `rdBusy`  out  NRD  per read port: the addressed register has an outstanding producer not satisfied this cycle.
- `wrEnA`, `wrAddrA`, `wrValA`  in  1/AW/DW  writeback port A (ALU).
- `wrEnB`, `wrAddrB`, `wrValB`  in  1/AW/DW  writeback port B (load); has priority over A.
- `issueEn`, `issueAddr`  in  1/AW  marks `issueAddr` as pending; the write arrives later.
- `anyBusy`  out  1  OR of all busy bits (registered state).
- `wrCollide`  out  1  registered pulse: both write ports targeted the same nonzero address in the previous cycle.

## Operation
- **Storage:** `NREGS` x `DW` array plus `busy[NREGS]`.
- **Write:** at posedge, if `wrEnA`, `regs[wrAddrA] <= wrValA`; if `wrEnB`, `regs[wrAddrB] <= wrValB`. On an address match, B's value is stored.
- **Zero register:** if `ZERO_REG` = 1, writes to address 0 are discarded, `busy[0]` stays 0, and reads of address 0 return 0 with `rdBusy` = 0.
- **Read port k, priority order:**
  1. Zero register returns 0.
  2. `wrEnB` && `wrAddrB` == addr returns `wrValB`.
  3. `wrEnA` && `wrAddrA` == addr returns `wrValA`.
  4. Otherwise returns `regs[addr]`.
- **rdBusy[k]:** `busy[addr]` && no enabled write port targets addr this cycle. A forwarded value counts as satisfied.
- **Scoreboard, per register r, next state:**
  - `issueEn` && `issueAddr` == r sets the bit to 1.
  - Otherwise, any enabled write to r clears it to 0.
  - Otherwise it holds.
  - Issue wins over a same-cycle write: the write belongs to the older producer, the new producer is still pending.
- **Write to a non-busy register:** legal; the data is stored and the busy bit is unaffected.
- **wrCollide:** set next cycle when `wrEnA` && `wrEnB` && `wrAddrA` == `wrAddrB` && the address is not the zero register. It is high for exactly one cycle per colliding cycle.
- **Reset:** clears all registers, all busy bits and `wrCollide`. Reset overrides same-cycle writes and issues; none take effect.

## Timing
- **Read latency:** 0 cycles, combinational from `rdAddr` and the write ports.
- **Write latency:** data is visible in the array 1 cycle after the write-enable edge, and forwarded in the same cycle.
- **Issue latency:** busy is visible on `rdBusy` and `anyBusy` 1 cycle after `issueEn`.
- **Reset values:** `anyBusy` = 0 and `wrCollide` = 0 after the reset edge. `rdVal` = 0 for all addresses unless a write is being forwarded. Forwarding is independent of `reset`. `rdBusy` = 0.
- **Write ports:** at most one write per port per cycle; no back-pressure; writes always complete.
- **Read port independence:** ports are fully independent; identical addresses on several ports return identical data.
- **Sizing:** depth and width wrap nothing. Addresses are exactly `AW` bits and every encoding is a valid register.

## Test plan
- **Reset clear:** write `0xA5` to r3, then assert `reset` with `wrEnA` = 1 to r3 = `0x11` -> the next cycle `rdVal` for r3 = `0x00`, `anyBusy` = 0.
- **Forwarding:** `wrEnA` r5 = `0x3C` with `rdAddr[0]` = 5 in the same cycle -> `rdVal[0]` = `0x3C` combinationally; r5 still reads `0x3C` the next cycle with no write.
- **Dual-write collision:** A writes r2 = `0x01` and B writes r2 = `0x02` in the same cycle -> same-cycle read = `0x02`, stored value = `0x02`, `wrCollide` = 1 for exactly one cycle. The same collision on r0 -> r0 reads 0 and `wrCollide` = 0.
- **Scoreboard:** issue r4 -> next cycle `rdBusy` = 1 for r4 and `anyBusy` = 1. Then `wrEnB` r4 = `0x77` -> `rdBusy` = 0 that same cycle with `rdVal` = `0x77`, and busy is clear afterwards.
- **Issue vs write:** issue r6 and write r6 in the same cycle while r6 is already busy -> r6 stays busy and the array holds the written data.
- **Parameter sweep:** `DW` = 16, `NREGS` = 16, `NRD` = 3, `ZERO_REG` = 0 -> r0 is writable (`0xBEEF` reads back); all three ports read distinct registers correctly.
